// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared data-memory types plus arbiter lock-state and port-count definitions
// Purpose : word/address types and memory size used by the data path, and the
//           lock-state enum and port count used by dmem_arbiter.
// Ports   : none (package).
package types_pkg;

   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 32;
   localparam int MEM_SIZE       = 64;
   localparam int NUM_DMEM_PORTS = 2;

   typedef logic [ADDR_W-1:0] address_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } arb_lock_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response bundle between the two cores and dmem_arbiter
// Purpose : groups the per-port request handshake and the registered response.
// Ports   : master (core side)  drives req_valid/req_we/req_addr/req_wdata[/req_lock],
//                               receives req_ready/rsp_valid/rsp_rdata/rsp_err.
//           slave  (arbiter)    the reverse.
// Config  : DMEM_ARB_LOCK_EN adds req_lock.
interface dmem_arbiter_if;
   import types_pkg::*;

   logic [NUM_DMEM_PORTS-1:0] req_valid;
   logic [NUM_DMEM_PORTS-1:0] req_we;
   address_t                  req_addr  [NUM_DMEM_PORTS];
   word_t                     req_wdata [NUM_DMEM_PORTS];
`ifdef DMEM_ARB_LOCK_EN
   logic [NUM_DMEM_PORTS-1:0] req_lock;
`endif
   logic [NUM_DMEM_PORTS-1:0] req_ready;
   logic [NUM_DMEM_PORTS-1:0] rsp_valid;
   word_t                     rsp_rdata;
   logic                      rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_ARB_LOCK_EN
      output req_lock,
`endif
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_ARB_LOCK_EN
      input  req_lock,
`endif
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - combinational two-way round-robin choice
// Purpose : picks one of two masked requesters; on a tie the port that was
//           not granted last wins.
// Ports   : i_valid[1:0] requests, i_last most recently granted port,
//           i_mask[1:0] ports eligible this cycle, o_grant[1:0] one-hot or zero.
module rr_picker (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   input  logic [1:0] i_mask,
   output logic [1:0] o_grant
);

   logic [1:0] w_cand;

   assign w_cand = i_valid & i_mask;

   always_comb begin
      o_grant = w_cand;
      if (w_cand == 2'b11) begin
         o_grant = i_last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data memory between two cores
// Purpose : grants one core per cycle, drives data_mem directly (combinational
//           read, write at the accept edge) and returns a registered response
//           one cycle after acceptance. Out-of-range accesses are flagged and
//           never touch memory.
// Ports   : i_clk, i_rst (async, active high)
//           bus          dmem_arbiter_if.slave request/response bundle
//           o_mem_we     data_mem write_enable
//           o_mem_addr   data_mem data_address
//           o_mem_wdata  data_mem write_data
//           i_mem_rdata  data_mem read_data (combinational)
// Config  : DMEM_ARB_LOCK_EN adds req_lock, the lock FSM, the lock counter and
//           the LOCK_MAX parameter (max consecutive locked cycles).
module dmem_arbiter
   import types_pkg::*;
`ifdef DMEM_ARB_LOCK_EN
#(
   parameter int unsigned LOCK_MAX = 16
)
`endif
(
   input  logic          i_clk,
   input  logic          i_rst,
   dmem_arbiter_if.slave bus,
   output logic          o_mem_we,
   output address_t      o_mem_addr,
   output word_t         o_mem_wdata,
   input  word_t         i_mem_rdata
);

   logic [1:0] w_mask;
   logic [1:0] w_grant;
   logic       w_accept;
   logic       w_winner;
   logic       w_we;
   logic       w_in_range;
   address_t   w_addr;
   word_t      w_wdata;
   logic       w_force_unlock;
   logic       w_force_last;

   logic       r_last;
   logic [1:0] r_rsp_valid;
   word_t      r_rsp_rdata;
   logic       r_rsp_err;

   rr_picker u_picker (
      .i_valid (bus.req_valid),
      .i_last  (r_last),
      .i_mask  (w_mask),
      .o_grant (w_grant)
   );

   assign w_accept = |w_grant;
   // With no grant w_winner is 0, so the memory port idles on port 0's request.
   assign w_winner = w_grant[1];
   assign w_addr   = bus.req_addr[w_winner];
   assign w_wdata  = bus.req_wdata[w_winner];
   assign w_we     = bus.req_we[w_winner];
   assign w_in_range = (w_addr < address_t'(MEM_SIZE));

   assign bus.req_ready = w_grant;
   assign o_mem_addr    = w_addr;
   assign o_mem_wdata   = w_wdata;
   assign o_mem_we      = w_accept && w_we && w_in_range;

`ifdef DMEM_ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   arb_lock_state_t  r_lock_state;
   arb_lock_state_t  w_lock_next;
   logic [CNT_W-1:0] r_lock_cnt;
   logic             w_win_lock;

   assign w_win_lock = bus.req_lock[w_winner];

   // Mask and expiry depend only on registered state, keeping the grant path
   // free of any loop through the next-state logic.
   always_comb begin
      w_mask = 2'b11;
      case (r_lock_state)
         LOCKED0: w_mask = 2'b01;
         LOCKED1: w_mask = 2'b10;
         default: w_mask = 2'b11;
      endcase
   end

   // The counter never exceeds LOCK_MAX-1: it clears on the edge that leaves
   // the lock, so reaching LOCK_MAX-1 means this is the last locked cycle.
   assign w_force_unlock = (r_lock_state != UNLOCKED) &&
                           (r_lock_cnt == CNT_W'(LOCK_MAX - 1));
   assign w_force_last   = (r_lock_state == LOCKED1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lock_state <= UNLOCKED;
      end else begin
         r_lock_state <= w_lock_next;
      end
   end

   always_comb begin
      w_lock_next = r_lock_state;
      case (r_lock_state)
         UNLOCKED: begin
            if (w_accept && w_win_lock) begin
               w_lock_next = w_winner ? LOCKED1 : LOCKED0;
            end
         end
         LOCKED0, LOCKED1: begin
            if (w_force_unlock || (w_accept && !w_win_lock)) begin
               w_lock_next = UNLOCKED;
            end
         end
         default: w_lock_next = UNLOCKED;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lock_cnt <= '0;
      end else if ((r_lock_state == UNLOCKED) || (w_lock_next == UNLOCKED)) begin
         r_lock_cnt <= '0;
      end else begin
         r_lock_cnt <= r_lock_cnt + 1'b1;
      end
   end
`else
   assign w_mask         = 2'b11;
   assign w_force_unlock = 1'b0;
   assign w_force_last   = 1'b0;
`endif

   // A forced unlock hands the pointer to the locking port so the starved
   // port wins the next tie.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (w_force_unlock) begin
         r_last <= w_force_last;
      end else if (w_accept) begin
         r_last <= w_winner;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_grant;
         if (w_accept) begin
            r_rsp_rdata <= (!w_we && w_in_range) ? i_mem_rdata : '0;
            r_rsp_err   <= !w_in_range;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural data_mem
module tb_dmem_arbiter;
   import types_pkg::*;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   logic     mem_we;
   address_t mem_addr;
   word_t    mem_wdata;
   word_t    mem_rdata;
   word_t    mem [64];

   int n_pass  = 0;
   int n_total = 0;

   dmem_arbiter_if bus ();

`ifdef DMEM_ARB_LOCK_EN
   dmem_arbiter #(.LOCK_MAX(4)) u_dut (
`else
   dmem_arbiter u_dut (
`endif
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (bus),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[5:0]];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'h1000_0000 + k;
      end else if (mem_we) begin
         mem[mem_addr[5:0]] <= mem_wdata;
      end
   end

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  exp_ready;
      logic        exp_mem_we;
      logic [1:0]  exp_rsp_valid;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic [1:0] valid, input logic [1:0] we,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      bus.req_valid    = valid;
      bus.req_we       = we;
      bus.req_addr[0]  = a0;
      bus.req_addr[1]  = a1;
      bus.req_wdata[0] = d0;
      bus.req_wdata[1] = d1;
   endtask

   initial begin
      drive(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
`ifdef DMEM_ARB_LOCK_EN
      bus.req_lock = 2'b00;
`endif
      //           valid  we     a0     a1      d0            d1            rdy    mwe   rspv   rdata          err
      vecs[0]  = '{2'b01, 2'b01, 8'd4,  8'd0,   32'hDEADBEEF, 32'd0,        2'b01, 1'b1, 2'b00, 32'd0,         1'b0};
      vecs[1]  = '{2'b10, 2'b00, 8'd0,  8'd4,   32'd0,        32'd0,        2'b10, 1'b0, 2'b01, 32'd0,         1'b0};
      vecs[2]  = '{2'b11, 2'b00, 8'd1,  8'd2,   32'd0,        32'd0,        2'b01, 1'b0, 2'b10, 32'hDEADBEEF,  1'b0};
      vecs[3]  = '{2'b11, 2'b00, 8'd3,  8'd2,   32'd0,        32'd0,        2'b10, 1'b0, 2'b01, 32'h1000_0001, 1'b0};
      vecs[4]  = '{2'b11, 2'b00, 8'd3,  8'd5,   32'd0,        32'd0,        2'b01, 1'b0, 2'b10, 32'h1000_0002, 1'b0};
      vecs[5]  = '{2'b11, 2'b00, 8'd6,  8'd5,   32'd0,        32'd0,        2'b10, 1'b0, 2'b01, 32'h1000_0003, 1'b0};
      vecs[6]  = '{2'b11, 2'b00, 8'd6,  8'd7,   32'd0,        32'd0,        2'b01, 1'b0, 2'b10, 32'h1000_0005, 1'b0};
      vecs[7]  = '{2'b11, 2'b00, 8'd9,  8'd7,   32'd0,        32'd0,        2'b10, 1'b0, 2'b01, 32'h1000_0006, 1'b0};
      vecs[8]  = '{2'b10, 2'b10, 8'd0,  8'd64,  32'd0,        32'h55,       2'b10, 1'b0, 2'b10, 32'h1000_0007, 1'b0};
      vecs[9]  = '{2'b01, 2'b00, 8'd63, 8'd0,   32'd0,        32'd0,        2'b01, 1'b0, 2'b10, 32'd0,         1'b1};
      vecs[10] = '{2'b10, 2'b00, 8'd0,  8'd200, 32'd0,        32'd0,        2'b10, 1'b0, 2'b01, 32'h1000_003F, 1'b0};
      vecs[11] = '{2'b01, 2'b01, 8'd10, 8'd0,   32'hA5A5_0001, 32'd0,       2'b01, 1'b1, 2'b10, 32'd0,         1'b1};
      vecs[12] = '{2'b01, 2'b00, 8'd10, 8'd0,   32'd0,        32'd0,        2'b01, 1'b0, 2'b01, 32'd0,         1'b0};
      vecs[13] = '{2'b00, 2'b00, 8'd0,  8'd0,   32'd0,        32'd0,        2'b00, 1'b0, 2'b01, 32'hA5A5_0001, 1'b0};
      vecs[14] = '{2'b00, 2'b00, 8'd0,  8'd0,   32'd0,        32'd0,        2'b00, 1'b0, 2'b00, 32'd0,         1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready_idle", {30'd0, bus.req_ready}, 32'd0);
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);

      for (int i = 0; i < 15; i++) begin
         #1;
         drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         #1;
         chk($sformatf("v%0d_req_ready", i), {30'd0, bus.req_ready}, {30'd0, vecs[i].exp_ready});
         chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_mem_we});
         chk($sformatf("v%0d_rsp_valid", i), {30'd0, bus.rsp_valid}, {30'd0, vecs[i].exp_rsp_valid});
         if (vecs[i].exp_rsp_valid != 2'b00 || i == 0) begin
            chk($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_rsp_err", i), {31'd0, bus.rsp_err}, {31'd0, vecs[i].exp_err});
         end
         @(posedge clk);
      end

      chk("oor_store_mem0_kept", mem[0], 32'h1000_0000);
      chk("store_mem10", mem[10], 32'hA5A5_0001);

      // Reset while a response is pending.
      #1;
      drive(2'b01, 2'b00, 8'd1, 8'd0, 32'd0, 32'd0);
      #1;
      chk("rstseq_accept", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      drive(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
      chk("rstseq_rsp_pending", {30'd0, bus.rsp_valid}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rstseq_rsp_dropped", {30'd0, bus.rsp_valid}, 32'd0);
      chk("rstseq_rdata_cleared", bus.rsp_rdata, 32'd0);
      drive(2'b11, 2'b00, 8'd2, 8'd3, 32'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstseq_tie_port0", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("rstseq_tie_then_port1", {30'd0, bus.req_ready}, 32'd2);

`ifdef DMEM_ARB_LOCK_EN
      drive(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(2'b11, 2'b00, 8'd8, 8'd9, 32'd0, 32'd0);
      bus.req_lock = 2'b01;
      #1;
      chk("lock_take_p0", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      drive(2'b11, 2'b01, 8'd8, 8'd9, 32'h0000_0077, 32'd0);
      bus.req_lock = 2'b00;
      #1;
      chk("lock_hold_p0_store", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      drive(2'b10, 2'b00, 8'd8, 8'd9, 32'd0, 32'd0);
      #1;
      chk("lock_released_p1", {30'd0, bus.req_ready}, 32'd2);
      @(posedge clk);
      #1;
      drive(2'b01, 2'b00, 8'd8, 8'd9, 32'd0, 32'd0);
      bus.req_lock = 2'b01;
      #1;
      chk("lockmax_take_p0", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      drive(2'b10, 2'b00, 8'd8, 8'd9, 32'd0, 32'd0);
      bus.req_lock = 2'b00;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("lockmax_starve%0d", c), {30'd0, bus.req_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      drive(2'b11, 2'b00, 8'd8, 8'd9, 32'd0, 32'd0);
      #1;
      chk("lockmax_forced_p1", {30'd0, bus.req_ready}, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
